regfile_2w_scoreboard: RTL and testbench

//  Next-generation register file for the pipelined core with a multicycle multiplier.
//  - Two read ports, feeding decode.
//  - Two write ports:
//    - port 0: ALU / memory writeback.
//    - port 1: multicycle MULT writeback.
//  - Per-register busy (scoreboard) bit: set when a MULT issues, cleared when its result is written.
//    The hazard unit stalls on RAW/WAW against in-flight MULT destinations.
//  - x0 is hardwired to zero.

---
 rtl/regfile_2w_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_regfile_2w_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w_scoreboard.sv
// Register file with two read ports, two write ports and a per-register busy
// scoreboard for the multicycle multiplier.
//
// Write port 0 carries ALU/memory writeback; write port 1 carries MULT
// writeback and also clears the busy bit of its destination. A MULT issue
// (busy_set_i) marks its destination pending until that write arrives. The
// hazard unit reads busy_1_o/busy_2_o to stall on RAW/WAW against in-flight
// MULT results. Register x0 always reads zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - write-through forwarding from both write ports to both read
//               ports. Port 0 has priority. A port-1 hit also reads busy as 0.
//   undefined - reads return the stored value and the stored busy bit.
//
// Ports
//   clk           system clock
//   arst_n        asynchronous active-low reset
//   we_0_i        write enable, port 0 (ALU/MEM)
//   waddr_0_i     write address, port 0
//   wdata_0_i     write data, port 0
//   we_1_i        write enable, port 1 (MULT); also clears busy[waddr_1_i]
//   waddr_1_i     write address, port 1
//   wdata_1_i     write data, port 1
//   busy_set_i    MULT issue: mark busy_addr_i pending
//   busy_addr_i   destination of the issuing MULT
//   raddr_1_i     read address 1
//   raddr_2_i     read address 2
//   rdata_1_o     read data 1 (combinational)
//   rdata_2_o     read data 2 (combinational)
//   busy_1_o      pending flag of raddr_1_i (combinational)
//   busy_2_o      pending flag of raddr_2_i (combinational)
//   busy_any_o    OR of all busy bits (registered)

module regfile_2w_scoreboard #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_REG  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              arst_n,

  input  logic              we_0_i,
  input  logic [ADDR_W-1:0] waddr_0_i,
  input  logic [DATA_W-1:0] wdata_0_i,

  input  logic              we_1_i,
  input  logic [ADDR_W-1:0] waddr_1_i,
  input  logic [DATA_W-1:0] wdata_1_i,

  input  logic              busy_set_i,
  input  logic [ADDR_W-1:0] busy_addr_i,

  input  logic [ADDR_W-1:0] raddr_1_i,
  input  logic [ADDR_W-1:0] raddr_2_i,
  output logic [DATA_W-1:0] rdata_1_o,
  output logic [DATA_W-1:0] rdata_2_o,
  output logic              busy_1_o,
  output logic              busy_2_o,
  output logic              busy_any_o
);

  localparam int unsigned NumRd = 2;

  // Storage. Entry 0 exists for uniform indexing but is never written.
  logic [DATA_W-1:0] regs_q [N_REG];
  logic [DATA_W-1:0] regs_d [N_REG];
  logic [N_REG-1:0]  busy_q, busy_d;
  logic              busy_any_q;

  ////////////////////
  // Next-state     //
  ////////////////////

  // Looping only over architectural indices 1..N_REG-1 means writes and
  // busy_set to x0 or to out-of-range addresses match nothing and drop out.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    for (int unsigned r = 1; r < N_REG; r++) begin
      // Port 0 wins a same-address data collision.
      if (we_0_i && (waddr_0_i == ADDR_W'(r))) begin
        regs_d[r] = wdata_0_i;
      end else if (we_1_i && (waddr_1_i == ADDR_W'(r))) begin
        regs_d[r] = wdata_1_i;
      end
      // A new MULT issue wins over a same-cycle writeback clear, so a
      // back-to-back MULT to the same destination stays pending.
      if (busy_set_i && (busy_addr_i == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (we_1_i && (waddr_1_i == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  ////////////////////
  // State          //
  ////////////////////

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned r = 0; r < N_REG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  assign busy_any_o = busy_any_q;

  ////////////////////
  // Read ports     //
  ////////////////////

  logic [ADDR_W-1:0] raddr [NumRd];
  logic [DATA_W-1:0] rdata [NumRd];
  logic              rbusy [NumRd];

  assign raddr[0] = raddr_1_i;
  assign raddr[1] = raddr_2_i;

`ifdef REGFILE_BYPASS_EN
  // Forward only to architectural addresses: x0 and out-of-range reads stay 0.
  function automatic logic addr_ok(logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < N_REG);
  endfunction
`endif

  always_comb begin
    for (int unsigned p = 0; p < NumRd; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      // Explicit compare-mux keeps out-of-range addresses at 0 for any N_REG.
      for (int unsigned r = 1; r < N_REG; r++) begin
        if (raddr[p] == ADDR_W'(r)) begin
          rdata[p] = regs_q[r];
          rbusy[p] = busy_q[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (addr_ok(raddr[p])) begin
        if (we_0_i && (waddr_0_i == raddr[p])) begin
          rdata[p] = wdata_0_i;
        end else if (we_1_i && (waddr_1_i == raddr[p])) begin
          rdata[p] = wdata_1_i;
        end
        // The MULT result is arriving this cycle, so the dependent
        // instruction need not stall on it.
        if (we_1_i && (waddr_1_i == raddr[p])) begin
          rbusy[p] = 1'b0;
        end
      end
`endif
    end
  end

  assign rdata_1_o = rdata[0];
  assign rdata_2_o = rdata[1];
  assign busy_1_o  = rbusy[0];
  assign busy_2_o  = rbusy[1];

endmodule

// File: tb/tb_regfile_2w_scoreboard.sv
module tb_regfile_2w_scoreboard;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 24;  // less than 2**AW so out-of-range addresses exist
  localparam int unsigned AW = 5;

  logic          clk;
  logic          arst_n;
  logic          we_0, we_1, busy_set;
  logic [AW-1:0] waddr_0, waddr_1, busy_addr, raddr_1, raddr_2;
  logic [DW-1:0] wdata_0, wdata_1, rdata_1, rdata_2;
  logic          busy_1, busy_2, busy_any;

  regfile_2w_scoreboard #(
    .DATA_W(DW),
    .N_REG (NR),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .we_0_i     (we_0),
    .waddr_0_i  (waddr_0),
    .wdata_0_i  (wdata_0),
    .we_1_i     (we_1),
    .waddr_1_i  (waddr_1),
    .wdata_1_i  (wdata_1),
    .busy_set_i (busy_set),
    .busy_addr_i(busy_addr),
    .raddr_1_i  (raddr_1),
    .raddr_2_i  (raddr_2),
    .rdata_1_o  (rdata_1),
    .rdata_2_o  (rdata_2),
    .busy_1_o   (busy_1),
    .busy_2_o   (busy_2),
    .busy_any_o (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          bs;
    logic [AW-1:0] ba;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;   // expected, sampled before the edge
    logic [DW-1:0] rd2;
    logic          b1;
    logic          b2;
    logic          bany;  // expected busy_any after the edge
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  vec_t exp_q [$];
  logic bany_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we_0 = 0; waddr_0 = '0; wdata_0 = '0;
    we_1 = 0; waddr_1 = '0; wdata_1 = '0;
    busy_set = 0; busy_addr = '0;
  endtask

`ifdef REGFILE_BYPASS_EN
  // Same-cycle forwarding changes what a read sees before the edge.
  function automatic void fwd(input vec_t v, input logic [AW-1:0] ra,
                              inout logic [DW-1:0] rd, inout logic b);
    if (ra != 0 && 32'(ra) < NR) begin
      if (v.we0 && v.wa0 == ra) rd = v.wd0;
      else if (v.we1 && v.wa1 == ra) rd = v.wd1;
      if (v.we1 && v.wa1 == ra) b = 1'b0;
    end
  endfunction
`endif

  initial begin
    vec_t e;
    logic eb;
    logic [DW-1:0] rd_t;
    logic          b_t;

    //             we0 wa0 wd0       we1 wa1 wd1       bs ba  ra1 ra2 rd1       rd2       b1 b2 bany
    vecs[0]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd0,  5'd0,
                 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd5,  16'h1234, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd5,  5'd0,
                 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    // x0 write: same cycle and next cycle both read 0
    vecs[2]  = '{1'b1, 5'd0,  16'hFFFF, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd5,  5'd0,
                 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd7,  5'd0,  5'd7,
                 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    // collision on r7, port 0 data wins, busy[7] cleared by we_1
    vecs[4]  = '{1'b1, 5'd7,  16'hAAAA, 1'b1, 5'd7, 16'h5555, 1'b0, 5'd0,  5'd7,  5'd5,
                 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd7,  5'd7,
                 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 1'b0};
    // scoreboard r3
    vecs[6]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd3,  5'd3,  5'd7,
                 16'h0000, 16'hAAAA, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd3,  5'd7,
                 16'h0000, 16'hAAAA, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3, 16'h0042, 1'b0, 5'd0,  5'd3,  5'd7,
                 16'h0000, 16'hAAAA, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd3,  5'd7,
                 16'h0042, 16'hAAAA, 1'b0, 1'b0, 1'b0};
    // set/clear race on r4
    vecs[10] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd4,  5'd0,  5'd4,
                 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd4, 16'h0077, 1'b1, 5'd4,  5'd0,  5'd4,
                 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    // out-of-range write and busy_set are dropped
    vecs[12] = '{1'b1, 5'd30, 16'hBEEF, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd25, 5'd0,  5'd4,
                 16'h0000, 16'h0077, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd4, 16'h0088, 1'b0, 5'd0,  5'd30, 5'd25,
                 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    // bypass case on r9
    vecs[14] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd9,  5'd4,  5'd9,
                 16'h0088, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd9, 16'h0BEE, 1'b0, 5'd0,  5'd4,  5'd9,
                 16'h0088, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd4,  5'd9,
                 16'h0088, 16'h0BEE, 1'b0, 1'b0, 1'b0};
    // highest valid register and first invalid one
    vecs[17] = '{1'b1, 5'd23, 16'h1111, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd23, 5'd23, 5'd24,
                 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0,  5'd23, 5'd24,
                 16'h1111, 16'h0000, 1'b1, 1'b0, 1'b1};

`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < NV; i++) begin
      rd_t = vecs[i].rd1; b_t = vecs[i].b1;
      fwd(vecs[i], vecs[i].ra1, rd_t, b_t);
      vecs[i].rd1 = rd_t; vecs[i].b1 = b_t;
      rd_t = vecs[i].rd2; b_t = vecs[i].b2;
      fwd(vecs[i], vecs[i].ra2, rd_t, b_t);
      vecs[i].rd2 = rd_t; vecs[i].b2 = b_t;
    end
`endif

    // Reset state
    arst_n = 1'b0;
    idle_inputs();
    raddr_1 = 5'd5; raddr_2 = 5'd3;
    #3;
    check("reset rdata_1", rdata_1, '0);
    check("reset busy_any", {15'd0, busy_any}, '0);
    #9 arst_n = 1'b1;

    // Table-driven vectors through the scoreboard queues
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we_0 = vecs[i].we0; waddr_0 = vecs[i].wa0; wdata_0 = vecs[i].wd0;
      we_1 = vecs[i].we1; waddr_1 = vecs[i].wa1; wdata_1 = vecs[i].wd1;
      busy_set = vecs[i].bs; busy_addr = vecs[i].ba;
      raddr_1 = vecs[i].ra1; raddr_2 = vecs[i].ra2;
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      check($sformatf("v%0d rdata_1", i), rdata_1, e.rd1);
      check($sformatf("v%0d rdata_2", i), rdata_2, e.rd2);
      check($sformatf("v%0d busy_1", i), {15'd0, busy_1}, {15'd0, e.b1});
      check($sformatf("v%0d busy_2", i), {15'd0, busy_2}, {15'd0, e.b2});
      bany_q.push_back(e.bany);
      @(posedge clk);
      #1;
      eb = bany_q.pop_front();
      check($sformatf("v%0d busy_any", i), {15'd0, busy_any}, {15'd0, eb});
    end

    // Mid-operation reset: r5=0x1234 and r23 busy at this point
    @(negedge clk);
    idle_inputs();
    raddr_1 = 5'd5; raddr_2 = 5'd23;
    #1;
    check("pre-reset rdata_1", rdata_1, 16'h1234);
    arst_n = 1'b0;
    #1;
    check("async reset rdata_1", rdata_1, '0);
    check("async reset busy_2", {15'd0, busy_2}, '0);
    check("async reset busy_any", {15'd0, busy_any}, '0);
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset r5", rdata_1, '0);
    check("post-reset busy_any", {15'd0, busy_any}, '0);

    // Long-latency MULT on r3: pending for several cycles, then written back
    @(negedge clk);
    busy_set = 1'b1; busy_addr = 5'd3; raddr_1 = 5'd3;
    #1;
    check("mult c0 busy_1", {15'd0, busy_1}, '0);
    @(posedge clk);
    #1;
    check("mult c0 busy_any", {15'd0, busy_any}, 16'd1);
    busy_set = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("mult c%0d busy_1", c), {15'd0, busy_1}, 16'd1);
    end
    @(negedge clk);
    we_1 = 1'b1; waddr_1 = 5'd3; wdata_1 = 16'h0042;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("mult wb busy_1", {15'd0, busy_1}, '0);
`else
    check("mult wb busy_1", {15'd0, busy_1}, 16'd1);
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check("mult done busy_1", {15'd0, busy_1}, '0);
    check("mult done busy_any", {15'd0, busy_any}, '0);
    check("mult done r3", rdata_1, 16'h0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
